// File: rtl/gray_counter_if.sv
// Control/status bundle for gray_counter: count controls in, registered count and flags out.
interface gray_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             wrap;
  logic             sat;

  modport master (output en, up_dn, load, load_val, input bin_out, gray_out, wrap, sat);
  modport slave  (input en, up_dn, load, load_val, output bin_out, gray_out, wrap, sat);
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray output, wrap or saturate at the limits,
// and a synchronous load taking either binary or Gray-coded values.
module gray_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          WRAP_EN   = 1'b1,
  parameter bit          LOAD_GRAY = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  gray_counter_if.slave bus
);

  logic [WIDTH-1:0] bin_q, bin_nxt, gray_q, load_bin;
  logic             wrap_q, wrap_nxt, sat_q, sat_nxt;
  logic             at_max, at_min;

  assign at_max = &bin_q;
  assign at_min = ~|bin_q;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    load_bin = bus.load_val;
    if (LOAD_GRAY)
      for (int i = 0; i < int'(WIDTH); i++) load_bin[i] = ^(bus.load_val >> i);
  end

  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    sat_nxt  = sat_q;
    if (bus.load) begin
      bin_nxt = load_bin;
      sat_nxt = 1'b0;
    end else if (bus.en) begin
      sat_nxt = 1'b0;
      if (bus.up_dn) begin
        if (at_max && !WRAP_EN) sat_nxt = 1'b1;
        else begin
          bin_nxt  = bin_q + 1'b1;
          wrap_nxt = at_max;
        end
      end else begin
        if (at_min && !WRAP_EN) sat_nxt = 1'b1;
        else begin
          bin_nxt  = bin_q - 1'b1;
          wrap_nxt = at_min;
        end
      end
    end
  end

  // Gray is encoded from the next binary value so both outputs move on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= bin_nxt ^ (bin_nxt >> 1);
      wrap_q <= wrap_nxt;
      sat_q  <= sat_nxt;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.gray_out = gray_q;
  assign bus.wrap     = wrap_q;
  assign bus.sat      = sat_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: wrap/binary-load, saturate, and Gray-load configurations.
module tb_gray_counter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] gray_seq [16];
  logic [3:0] prev_gray;

  always #5 clk = ~clk;

  gray_counter_if #(.WIDTH(4)) ia ();
  gray_counter_if #(.WIDTH(4)) ib ();
  gray_counter_if #(.WIDTH(4)) ic ();

  gray_counter #(.WIDTH(4), .WRAP_EN(1'b1), .LOAD_GRAY(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  gray_counter #(.WIDTH(4), .WRAP_EN(1'b0), .LOAD_GRAY(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  gray_counter #(.WIDTH(4), .WRAP_EN(1'b1), .LOAD_GRAY(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ab, input logic [3:0] ag,
                         input logic aw, input logic as, input logic [3:0] eb,
                         input logic [3:0] eg, input logic ew, input logic es);
    chk({tag, ".bin"}, 32'(ab), 32'(eb));
    chk({tag, ".gray"}, 32'(ag), 32'(eg));
    chk({tag, ".wrap"}, 32'(aw), 32'(ew));
    chk({tag, ".sat"}, 32'(as), 32'(es));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    gray_seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    rst_n = 1'b0;
    ia.en = 0; ia.up_dn = 0; ia.load = 0; ia.load_val = '0;
    ib.en = 0; ib.up_dn = 0; ib.load = 0; ib.load_val = '0;
    ic.en = 0; ic.up_dn = 0; ic.load = 0; ic.load_val = '0;
    step; step;
    chk_out("rst_a", ia.bin_out, ia.gray_out, ia.wrap, ia.sat, 4'h0, 4'h0, 0, 0);
    chk_out("rst_b", ib.bin_out, ib.gray_out, ib.wrap, ib.sat, 4'h0, 4'h0, 0, 0);
    chk_out("rst_c", ic.bin_out, ic.gray_out, ic.wrap, ic.sat, 4'h0, 4'h0, 0, 0);

    // Full up-count through rollover
    rst_n = 1'b1; ia.en = 1; ia.up_dn = 1;
    prev_gray = ia.gray_out;
    for (int k = 1; k <= 16; k++) begin
      step;
      chk_out($sformatf("up%0d", k), ia.bin_out, ia.gray_out, ia.wrap, ia.sat,
              4'(k), gray_seq[k % 16], (k == 16), 0);
      chk($sformatf("onebit%0d", k), 32'($countones(prev_gray ^ ia.gray_out)), 32'd1);
      prev_gray = ia.gray_out;
    end

    // Down-count from 0 wraps to all-ones
    ia.up_dn = 0;
    step; chk_out("dn_wrap", ia.bin_out, ia.gray_out, ia.wrap, ia.sat, 4'hF, 4'h8, 1, 0);
    step; chk_out("dn_next", ia.bin_out, ia.gray_out, ia.wrap, ia.sat, 4'hE, 4'h9, 0, 0);
    ia.en = 0;
    step; chk_out("hold_a", ia.bin_out, ia.gray_out, ia.wrap, ia.sat, 4'hE, 4'h9, 0, 0);

    // Load beats count
    ia.load = 1; ia.en = 1; ia.up_dn = 1; ia.load_val = 4'h5;
    step; chk_out("load_en", ia.bin_out, ia.gray_out, ia.wrap, ia.sat, 4'h5, 4'h7, 0, 0);
    ia.load_val = 4'hF;
    step; chk_out("load_max", ia.bin_out, ia.gray_out, ia.wrap, ia.sat, 4'hF, 4'h8, 0, 0);
    ia.load = 0;
    step; chk_out("roll_up", ia.bin_out, ia.gray_out, ia.wrap, ia.sat, 4'h0, 4'h0, 1, 0);

    // Reset mid-count
    ia.load = 1; ia.load_val = 4'hB;
    step; chk_out("load_b", ia.bin_out, ia.gray_out, ia.wrap, ia.sat, 4'hB, 4'hE, 0, 0);
    ia.load = 0; rst_n = 1'b0;
    step; chk_out("rst_mid", ia.bin_out, ia.gray_out, ia.wrap, ia.sat, 4'h0, 4'h0, 0, 0);
    rst_n = 1'b1;
    step; chk_out("post_rst", ia.bin_out, ia.gray_out, ia.wrap, ia.sat, 4'h1, 4'h1, 0, 0);
    ia.en = 0;

    // Saturation
    ib.load = 1; ib.load_val = 4'hE;
    step; chk_out("b_load", ib.bin_out, ib.gray_out, ib.wrap, ib.sat, 4'hE, 4'h9, 0, 0);
    ib.load = 0; ib.en = 1; ib.up_dn = 1;
    step; chk_out("b_up1", ib.bin_out, ib.gray_out, ib.wrap, ib.sat, 4'hF, 4'h8, 0, 0);
    step; chk_out("b_up2", ib.bin_out, ib.gray_out, ib.wrap, ib.sat, 4'hF, 4'h8, 0, 1);
    step; chk_out("b_up3", ib.bin_out, ib.gray_out, ib.wrap, ib.sat, 4'hF, 4'h8, 0, 1);
    ib.en = 0;
    step; chk_out("b_hold", ib.bin_out, ib.gray_out, ib.wrap, ib.sat, 4'hF, 4'h8, 0, 1);
    ib.en = 1; ib.up_dn = 0;
    step; chk_out("b_off", ib.bin_out, ib.gray_out, ib.wrap, ib.sat, 4'hE, 4'h9, 0, 0);
    ib.load = 1; ib.load_val = 4'h1;
    step; chk_out("b_load1", ib.bin_out, ib.gray_out, ib.wrap, ib.sat, 4'h1, 4'h1, 0, 0);
    ib.load = 0;
    step; chk_out("b_dn0", ib.bin_out, ib.gray_out, ib.wrap, ib.sat, 4'h0, 4'h0, 0, 0);
    step; chk_out("b_dnsat", ib.bin_out, ib.gray_out, ib.wrap, ib.sat, 4'h0, 4'h0, 0, 1);
    ib.load = 1; ib.load_val = 4'h5;
    step; chk_out("b_ldclr", ib.bin_out, ib.gray_out, ib.wrap, ib.sat, 4'h5, 4'h7, 0, 0);
    ib.load = 0; ib.en = 0;

    // Gray-coded load
    ic.load = 1; ic.load_val = 4'hD;
    step; chk_out("c_load", ic.bin_out, ic.gray_out, ic.wrap, ic.sat, 4'h9, 4'hD, 0, 0);
    ic.load_val = 4'h8;
    step; chk_out("c_loadmax", ic.bin_out, ic.gray_out, ic.wrap, ic.sat, 4'hF, 4'h8, 0, 0);
    ic.load = 0; ic.en = 1; ic.up_dn = 1;
    step; chk_out("c_roll", ic.bin_out, ic.gray_out, ic.wrap, ic.sat, 4'h0, 4'h0, 1, 0);
    ic.en = 0;
    step; chk_out("c_hold", ic.bin_out, ic.gray_out, ic.wrap, ic.sat, 4'h0, 4'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
